// File: rtl/light_ctrl.sv
// Two-road traffic-light phase controller advanced by a 1 Hz tick enable.
// The remaining seconds are kept as BCD digits; the lamps are decoded from the state register.
module light_ctrl #(
    parameter int T_GREEN_A = 40,
    parameter int T_GREEN_B = 20,
    parameter int T_YELLOW  = 5,
    parameter int T_ALLRED  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       night,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    typedef enum logic [2:0] {
        A_GREEN, A_YELLOW, B_GREEN, B_YELLOW, NIGHT, ALL_RED
    } state_t;

    // Phase durations are converted to BCD when the design is elaborated.
    localparam logic [7:0] LD_GA = {4'(T_GREEN_A / 10), 4'(T_GREEN_A % 10)};
    localparam logic [7:0] LD_GB = {4'(T_GREEN_B / 10), 4'(T_GREEN_B % 10)};
    localparam logic [7:0] LD_Y  = {4'(T_YELLOW / 10),  4'(T_YELLOW % 10)};
    localparam logic [7:0] LD_AR = {4'(T_ALLRED / 10),  4'(T_ALLRED % 10)};

    state_t     state, state_nxt;
    logic [3:0] tens, tens_nxt;
    logic [3:0] ones, ones_nxt;
    logic       flash, flash_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= A_GREEN;
            tens  <= LD_GA[7:4];
            ones  <= LD_GA[3:0];
            flash <= 1'b0;
        end else begin
            state <= state_nxt;
            tens  <= tens_nxt;
            ones  <= ones_nxt;
            flash <= flash_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tens_nxt  = tens;
        ones_nxt  = ones;
        flash_nxt = flash;
        if (tick) begin
            // Night request wins over phase expiry on the same tick.
            if (state != NIGHT && night) begin
                state_nxt = NIGHT;
                tens_nxt  = 4'd0;
                ones_nxt  = 4'd0;
                flash_nxt = 1'b1;
            end else if (state == NIGHT) begin
                if (night) begin
                    flash_nxt = ~flash;
                end else begin
                    state_nxt            = ALL_RED;
                    {tens_nxt, ones_nxt} = LD_AR;
                    flash_nxt            = 1'b0;
                end
            end else if (tens == 4'd0 && ones == 4'd1) begin
                case (state)
                    A_GREEN: begin
                        state_nxt            = A_YELLOW;
                        {tens_nxt, ones_nxt} = LD_Y;
                    end
                    A_YELLOW: begin
                        state_nxt            = B_GREEN;
                        {tens_nxt, ones_nxt} = LD_GB;
                    end
                    B_GREEN: begin
                        state_nxt            = B_YELLOW;
                        {tens_nxt, ones_nxt} = LD_Y;
                    end
                    default: begin
                        state_nxt            = A_GREEN;
                        {tens_nxt, ones_nxt} = LD_GA;
                    end
                endcase
            end else if (ones == 4'd0) begin
                ones_nxt = 4'd9;
                tens_nxt = tens - 4'd1;
            end else begin
                ones_nxt = ones - 4'd1;
            end
        end
    end

    always_comb begin
        light_a = 3'b100;
        light_b = 3'b100;
        case (state)
            A_GREEN:  light_a = 3'b001;
            A_YELLOW: light_a = 3'b010;
            B_GREEN:  light_b = 3'b001;
            B_YELLOW: light_b = 3'b010;
            NIGHT: begin
                light_a = {1'b0, flash, 1'b0};
                light_b = {1'b0, flash, 1'b0};
            end
            default: ;
        endcase
    end

    assign sec_tens = tens;
    assign sec_ones = ones;

endmodule

// File: tb/tb_light_ctrl.sv
// Self-checking bench for light_ctrl: directed scenarios plus randomized tick/night traffic
// compared against a phase/seconds model kept in plain integers.
module tb_light_ctrl;

    localparam int TGA = 40, TGB = 20, TY = 5, TAR = 2;
    localparam int P_AG = 0, P_AY = 1, P_BG = 2, P_BY = 3, P_NT = 4, P_AR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       night = 1'b0;
    logic [2:0] light_a, light_b;
    logic [3:0] sec_tens, sec_ones;

    int checks = 0;
    int errors = 0;

    int m_ph, m_rem;
    bit m_fl;
    bit nmode;

    light_ctrl #(.T_GREEN_A(TGA), .T_GREEN_B(TGB), .T_YELLOW(TY), .T_ALLRED(TAR)) dut (
        .clk(clk), .rst(rst), .tick(tick), .night(night),
        .light_a(light_a), .light_b(light_b), .sec_tens(sec_tens), .sec_ones(sec_ones)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int ph);
        case (ph)
            P_AG: return TGA;
            P_AY, P_BY: return TY;
            P_BG: return TGB;
            P_AR: return TAR;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] lamps(input int ph, input bit fl);
        case (ph)
            P_AG: return {3'b001, 3'b100};
            P_AY: return {3'b010, 3'b100};
            P_BG: return {3'b100, 3'b001};
            P_BY: return {3'b100, 3'b010};
            P_AR: return {3'b100, 3'b100};
            default: return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
        endcase
    endfunction

    task automatic model_reset();
        m_ph  = P_AG;
        m_rem = TGA;
        m_fl  = 1'b0;
    endtask

    task automatic model_tick(input bit n);
        if (m_ph != P_NT && n) begin
            m_ph = P_NT; m_rem = 0; m_fl = 1'b1;
        end else if (m_ph == P_NT) begin
            if (n) m_fl = !m_fl;
            else begin m_ph = P_AR; m_rem = TAR; m_fl = 1'b0; end
        end else if (m_rem == 1) begin
            m_ph  = (m_ph == P_AR || m_ph == P_BY) ? P_AG : m_ph + 1;
            m_rem = dur(m_ph);
        end else begin
            m_rem = m_rem - 1;
        end
    endtask

    function automatic logic [13:0] observed();
        return {light_a, light_b, sec_tens, sec_ones};
    endfunction

    function automatic logic [13:0] expected();
        return {lamps(m_ph, m_fl), 4'(m_rem / 10), 4'(m_rem % 10)};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed a=%b b=%b digits=%h/%h, expected a=%b b=%b digits=%h/%h",
                   tag, obs[13:11], obs[10:8], obs[7:4], obs[3:0],
                   exp[13:11], exp[10:8], exp[7:4], exp[3:0]);
        end
    endtask

    // One clock: drive, step past the edge, update the model on ticks, compare.
    task automatic cyc(input bit t, input bit n, input string tag);
        tick  = t;
        night = n;
        @(posedge clk);
        #1;
        tick = 1'b0;
        if (t) model_tick(n);
        chk(tag, observed(), expected());
    endtask

    task automatic ticks(input int cnt, input bit n);
        for (int i = 0; i < cnt; i++) begin
            cyc(1'b1, n, "tick");
            repeat (9) cyc(1'b0, 1'($urandom_range(0, 1)), "idle");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        night = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();
        chk("reset", observed(), {3'b001, 3'b100, 4'd4, 4'd0});
        repeat (50) cyc(1'b0, 1'b0, "reset_hold");
        chk("reset_held", observed(), {3'b001, 3'b100, 4'd4, 4'd0});

        // Full cycle and BCD borrow at a 10-cycle tick period.
        ticks(1, 1'b0);
        chk("borrow_1", observed(), {3'b001, 3'b100, 4'd3, 4'd9});
        ticks(29, 1'b0);
        chk("borrow_30", observed(), {3'b001, 3'b100, 4'd1, 4'd0});
        ticks(1, 1'b0);
        chk("borrow_31", observed(), {3'b001, 3'b100, 4'd0, 4'd9});
        ticks(9, 1'b0);
        chk("cycle_40", observed(), {3'b010, 3'b100, 4'd0, 4'd5});
        ticks(5, 1'b0);
        chk("cycle_45", observed(), {3'b100, 3'b001, 4'd2, 4'd0});
        ticks(20, 1'b0);
        chk("cycle_65", observed(), {3'b100, 3'b010, 4'd0, 4'd5});
        ticks(5, 1'b0);
        chk("cycle_70", observed(), {3'b001, 3'b100, 4'd4, 4'd0});

        // Night entry from B_GREEN at 17 s, flashing, then all-red exit.
        do_reset();
        ticks(48, 1'b0);
        chk("b_green_17", observed(), {3'b100, 3'b001, 4'd1, 4'd7});
        ticks(1, 1'b1);
        chk("night_enter", observed(), {3'b010, 3'b010, 4'd0, 4'd0});
        ticks(1, 1'b1);
        chk("night_flash_off", observed(), {3'b000, 3'b000, 4'd0, 4'd0});
        ticks(1, 1'b1);
        chk("night_flash_on", observed(), {3'b010, 3'b010, 4'd0, 4'd0});
        ticks(1, 1'b0);
        chk("all_red", observed(), {3'b100, 3'b100, 4'd0, 4'd2});
        ticks(2, 1'b0);
        chk("all_red_exit", observed(), {3'b001, 3'b100, 4'd4, 4'd0});

        // Night request on the tick where A_YELLOW would expire.
        do_reset();
        ticks(44, 1'b0);
        chk("a_yellow_01", observed(), {3'b010, 3'b100, 4'd0, 4'd1});
        ticks(1, 1'b1);
        chk("night_priority", observed(), {3'b010, 3'b010, 4'd0, 4'd0});

        // Asynchronous reset in NIGHT between edges, with a simultaneous tick.
        tick  = 1'b1;
        night = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", observed(), {3'b001, 3'b100, 4'd4, 4'd0});
        @(posedge clk);
        #1;
        chk("reset_tick_lost", observed(), {3'b001, 3'b100, 4'd4, 4'd0});
        rst   = 1'b0;
        tick  = 1'b0;
        night = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, "first_tick");
        chk("first_after_reset", observed(), {3'b001, 3'b100, 4'd3, 4'd9});

        // Randomized traffic: back-to-back ticks, gaps, and night noise between ticks.
        nmode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) nmode = !nmode;
            if ($urandom_range(0, 2) != 0)
                cyc(1'b1, nmode, "rand_tick");
            else
                cyc(1'b0, 1'($urandom_range(0, 1)), "rand_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
